muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide execution unit. It sits beside the 64-bit ALU in the multicycle datapath.
- Operands come from the regA/regB register outputs. The result feeds the register-bank write-data mux.
- The control unit pulses start, holds its state while busy=1, and writes the result back on done.
- Shift-add multiply and restoring divide, one bit per cycle.

Parameters:
XLEN, 64, operand/result width (only 64 is supported)
CNT_W, 7, iteration counter width (must hold XLEN)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1  in  XLEN  operand A (regA output)
rs2  in  XLEN  operand B (regB output)
busy  out  1  high from the accepting edge until done
done  out  1  one-cycle pulse; result valid
result  out  XLEN  final value; held until the next accepted start

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, result=0, all internal registers=0. Reset mid-operation aborts immediately; no done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 at edge E latches op, rs1 and rs2; goes to CALC; busy=1; counter=0.
  - Operands are converted to magnitudes per op signedness. MULH: both signed. MULHSU: rs1 signed, rs2 unsigned. DIV/REM: both signed. Others: unsigned.
  - The negate flag is recorded:
    - product: sign(a) XOR sign(b);
    - quotient: sign(a) XOR sign(b);
    - remainder: sign(a).
- CALC: exactly XLEN cycles, counter increments each cycle.
  - Multiply: 128-bit accumulator, shift-add on the multiplier LSB.
  - Divide: restoring step. Remainder is shifted left with the next dividend bit; subtract the divisor if the result is non-negative; the quotient bit is set accordingly.
  - When counter=XLEN-1, go to FIX.
- FIX, 1 cycle: apply the two's-complement negate flag, then select the output.
  - MUL: low 64 bits.
  - MULH*: high 64 bits.
  - DIV*: quotient.
  - REM*: remainder.
  - Load the result register. Go to DONE.
- DONE, 1 cycle: done=1, busy=1. Next state is IDLE, where busy=0.
- Latency: start accepted at edge E; done is high in the cycle after edge E+XLEN+1 (66 cycles for XLEN=64). A new start is accepted on the first IDLE edge after done.
- start while busy=1 is ignored; the operation in flight is unaffected. rs1, rs2 and op may change freely after acceptance.
- Divide by zero (rs2=0), decided in FIX, same latency:
  - DIV/DIVU: result=all ones (64'hFFFF_FFFF_FFFF_FFFF).
  - REM/REMU: result=rs1 as latched.
- Signed overflow (DIV with rs1=64'h8000_0000_0000_0000, rs2=all ones): quotient=64'h8000_0000_0000_0000, REM=0.
- No exceptions or flags are produced. Same latency for every op and operand.
- result is registered and stable between done pulses.

Decomposition:
- Package muldiv_pkg holds:
  - XLEN;
  - op enum muldiv_op_t with the 8 encodings above;
  - state enum muldiv_state_t {IDLE, CALC, FIX, DONE};
  - is_signed_a/is_signed_b/is_div helper functions.
- One sub-module is natural: muldiv_signfix. It is combinational and performs magnitude conversion and final negation/selection. It is instanced once at entry and once in FIX, or the same logic is shared.

Test Plan:
- MUL rs1=7, rs2=-3 (64'hFFFF_FFFF_FFFF_FFFD) -> done exactly 66 cycles after start; result=64'hFFFF_FFFF_FFFF_FFEB; MULH same operands -> all ones; MULHU -> 64'h0000_0000_0000_0006.
- DIV rs1=-20, rs2=6 -> result=-3 (64'hFFFF_FFFF_FFFF_FFFD); REM -> -2; DIVU rs1=20, rs2=6 -> 3; REMU -> 2.
- Divide by zero: DIVU rs1=123, rs2=0 -> all ones; REM rs1=-5, rs2=0 -> 64'hFFFF_FFFF_FFFF_FFFB; latency still 66.
- Overflow: DIV rs1=64'h8000_0000_0000_0000, rs2=-1 -> 64'h8000_0000_0000_0000; REM -> 0.
- Start pulsed again during CALC with different operands -> ignored; first result delivered unchanged; done pulses once; result holds after done while rs1/rs2 change.
- Reset driven low at cycle 30 of a DIV -> busy=0, done=0, result=0 immediately (asynchronous); after release, MULHSU rs1=-1, rs2=2 -> result=all ones in 66 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 7;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_t;

    function automatic logic is_signed_a(muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_div(muldiv_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the control unit (master) and the muldiv unit (slave).
interface muldiv_if;
    import muldiv_pkg::*;

    logic            start;
    muldiv_op_t      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, rs1, rs2, input busy, done, result);
    modport slave  (input start, op, rs1, rs2, output busy, done, result);

endinterface

// File: rtl/muldiv_signfix.sv
// Sign handling around the unsigned core: operand magnitudes at entry,
// final negation, result selection and divide-by-zero overrides at the end.
module muldiv_signfix
    import muldiv_pkg::*;
(
    input  muldiv_op_t        op,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    output logic [XLEN-1:0]   magA,
    output logic [XLEN-1:0]   magB,
    output logic              negate,
    input  muldiv_op_t        fixOp,
    input  logic [2*XLEN-1:0] acc,
    input  logic              fixNegate,
    input  logic              divZero,
    input  logic [XLEN-1:0]   rs1Held,
    output logic [XLEN-1:0]   fixResult
);

    logic              negA;
    logic              negB;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;

    always_comb begin
        negA   = is_signed_a(op) & rs1[XLEN-1];
        negB   = is_signed_b(op) & rs2[XLEN-1];
        magA   = negA ? -rs1 : rs1;
        magB   = negB ? -rs2 : rs2;
        // The remainder takes the dividend's sign; everything else the XOR.
        negate = (op == OP_REM) ? negA : (negA ^ negB);
    end

    always_comb begin
        product   = fixNegate ? -acc : acc;
        quotient  = fixNegate ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        remainder = fixNegate ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        unique case (fixOp)
            OP_MUL:                      fixResult = product[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fixResult = product[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fixResult = divZero ? '1 : quotient;
            default:                     fixResult = divZero ? rs1Held : remainder;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide: shift-add multiply and restoring divide,
// one bit per cycle, fixed latency regardless of op or operands.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    muldiv_if.slave  bus
);

    muldiv_state_t     state, nextState;
    logic [CNT_W-1:0]  count;
    muldiv_op_t        opReg;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   operand;
    logic              negReg;
    logic              divZeroReg;
    logic [XLEN-1:0]   rs1Reg;
    logic [XLEN-1:0]   resultReg;

    logic [XLEN-1:0]   magA, magB, fixResult;
    logic              negate;
    logic              accept;

    logic [XLEN:0]     mulSum;
    logic [2*XLEN-1:0] mulNext;
    logic [XLEN:0]     divTmp;
    logic [XLEN:0]     divDiff;
    logic              divGe;
    logic [2*XLEN-1:0] divNext;

    muldiv_signfix signFix (
        .op        (bus.op),
        .rs1       (bus.rs1),
        .rs2       (bus.rs2),
        .magA      (magA),
        .magB      (magB),
        .negate    (negate),
        .fixOp     (opReg),
        .acc       (acc),
        .fixNegate (negReg),
        .divZero   (divZeroReg),
        .rs1Held   (rs1Reg),
        .fixResult (fixResult)
    );

    assign accept     = (state == IDLE) && bus.start;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = resultReg;

    // Multiply keeps {partial, multiplier} in acc and shifts right;
    // divide keeps {remainder, dividend/quotient} and shifts left.
    always_comb begin
        mulSum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        mulNext = {mulSum, acc[XLEN-1:1]};
        divTmp  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        divDiff = divTmp - {1'b0, operand};
        divGe   = (divTmp >= {1'b0, operand});
        divNext = {(divGe ? divDiff[XLEN-1:0] : divTmp[XLEN-1:0]), acc[XLEN-2:0], divGe};
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (bus.start) nextState = CALC;
            CALC: if (count == CNT_W'(XLEN-1)) nextState = FIX;
            FIX:  nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            opReg      <= OP_MUL;
            acc        <= '0;
            operand    <= '0;
            negReg     <= 1'b0;
            divZeroReg <= 1'b0;
            rs1Reg     <= '0;
            resultReg  <= '0;
        end else if (accept) begin
            count      <= '0;
            opReg      <= bus.op;
            rs1Reg     <= bus.rs1;
            negReg     <= negate;
            divZeroReg <= (bus.rs2 == '0);
            operand    <= is_div(bus.op) ? magB : magA;
            acc        <= {{XLEN{1'b0}}, (is_div(bus.op) ? magA : magB)};
        end else if (state == CALC) begin
            count <= count + 1'b1;
            acc   <= is_div(opReg) ? divNext : mulNext;
        end else if (state == FIX) begin
            resultReg <= fixResult;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV64M cases, corner cases,
// start-while-busy, asynchronous abort, and a few randomized ops.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clock;
    logic reset;
    int   assertCount;
    int   failCount;

    logic [XLEN-1:0] expQ[$];
    string           tagQ[$];

    muldiv_if bus();

    muldiv_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkValue(input string tag, input logic [XLEN-1:0] observed,
                              input logic [XLEN-1:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [XLEN-1:0] refModel(input muldiv_op_t op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0]     ea, eb, p;
        logic signed [XLEN-1:0] sa, sb;
        logic                  ovf;
        sa  = a;
        sb  = b;
        ovf = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        ea  = (op inside {OP_MULH, OP_MULHSU}) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
        eb  = (op == OP_MULH) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        p   = ea * eb;
        case (op)
            OP_MUL:                      return p[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return p[2*XLEN-1:XLEN];
            OP_DIV:  return (b == '0) ? '1 : (ovf ? a : XLEN'(sa / sb));
            OP_DIVU: return (b == '0) ? '1 : a / b;
            OP_REM:  return (b == '0) ? a : (ovf ? '0 : XLEN'(sa % sb));
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    // Issues one op, scrambles the inputs after acceptance, optionally re-pulses
    // start at cycle pokeAt, then checks latency, result and post-done state.
    task automatic runOp(input muldiv_op_t op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] expected,
                         input string tag, input int pokeAt);
        int              cycles;
        logic            seen;
        logic [XLEN-1:0] exp;
        string           t;
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs1   = a;
        bus.rs2   = b;
        expQ.push_back(expected);
        tagQ.push_back(tag);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 200) begin
            @(negedge clock);
            cycles++;
            bus.start = (cycles == pokeAt);
            if (cycles == 2 || cycles == pokeAt) begin
                bus.rs1 = {$urandom, $urandom};
                bus.rs2 = {$urandom, $urandom};
                bus.op  = muldiv_op_t'(3'($urandom));
            end
            if (bus.done) seen = 1'b1;
        end
        exp = expQ.pop_front();
        t   = tagQ.pop_front();
        checkValue({t, " latency"}, XLEN'(cycles), 64'd66);
        checkValue(t, bus.result, exp);
        checkValue({t, " busy at done"}, XLEN'(bus.busy), 64'd1);
        @(negedge clock);
        bus.rs1 = ~bus.rs1;
        bus.rs2 = ~bus.rs2;
        #1;
        checkValue({t, " done cleared"}, XLEN'(bus.done), 64'd0);
        checkValue({t, " busy cleared"}, XLEN'(bus.busy), 64'd0);
        checkValue({t, " result held"}, bus.result, exp);
    endtask

    initial begin
        int              extraDone;
        muldiv_op_t      rop;
        logic [XLEN-1:0] ra, rb;

        assertCount = 0;
        failCount   = 0;
        bus.start   = 1'b0;
        bus.op      = OP_MUL;
        bus.rs1     = '0;
        bus.rs2     = '0;
        reset       = 1'b0;
        repeat (3) @(negedge clock);
        checkValue("reset busy", XLEN'(bus.busy), 64'd0);
        checkValue("reset done", XLEN'(bus.done), 64'd0);
        checkValue("reset result", bus.result, 64'd0);
        reset = 1'b1;

        runOp(OP_MUL,   64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, "mul", 0);
        runOp(OP_MULH,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, "mulh", 0);
        runOp(OP_MULHU, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_0000_0006, "mulhu", 0);
        runOp(OP_DIV,   64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, "div", 0);
        runOp(OP_REM,   64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, "rem", 0);
        runOp(OP_DIVU,  64'd20, 64'd6, 64'd3, "divu", 0);
        runOp(OP_REMU,  64'd20, 64'd6, 64'd2, "remu", 0);
        runOp(OP_DIVU,  64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, "divu by zero", 0);
        runOp(OP_REM,   64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, "rem by zero", 0);
        runOp(OP_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, "div overflow", 0);
        runOp(OP_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "rem overflow", 0);

        // A second start mid-CALC must neither disturb the result nor add a done pulse.
        runOp(OP_MUL, 64'd1000, 64'd3000, 64'd3000000, "start while busy", 10);
        extraDone = 0;
        repeat (70) begin
            @(negedge clock);
            if (bus.done) extraDone++;
        end
        checkValue("single done pulse", XLEN'(extraDone), 64'd0);

        // Asynchronous abort in the middle of a divide.
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.rs1   = 64'd1000;
        bus.rs2   = 64'd7;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (29) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checkValue("abort busy", XLEN'(bus.busy), 64'd0);
        checkValue("abort done", XLEN'(bus.done), 64'd0);
        checkValue("abort result", bus.result, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        runOp(OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu after abort", 0);

        for (int i = 0; i < 8; i++) begin
            rop = muldiv_op_t'(3'($urandom));
            ra  = {$urandom, $urandom};
            rb  = (i % 2 == 0) ? {$urandom, $urandom} : XLEN'($urandom_range(1, 1000));
            if (i == 5) rb = ~rb + 64'd1;
            runOp(rop, ra, rb, refModel(rop, ra, rb), $sformatf("random %0d op %0d", i, rop), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
